// File: rtl/fsm_par_pkg.sv
`timescale 1ns/1ps
// Shared state encoding and the parity helper used by the transmitter and its bench.
package fsm_par_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DATA   = 3'd1;
  localparam logic [2:0] PARITY = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic par_of(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/par_tx_shreg.sv
`timescale 1ns/1ps
// Load/shift register for the serial transmitter: bit counter, last-bit flag, and the
// bit that will be on the line after this edge.
module par_tx_shreg #(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              bit_o,
  output logic              last_o
);

  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= din_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sh_q  <= sh_q >> 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // When shifting, the line takes the bit that is about to move into position 0.
  assign bit_o  = shift_i ? sh_q[1] : sh_q[0];
  assign last_o = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/fsm_par_gen_tx.sv
`timescale 1ns/1ps
// Serial parity transmitter: LSB-first word followed by one parity bit, all outputs registered.
// Define PAR_TX_FRAME_EN to wrap each frame in a START (1) and STOP (0) bit.
module fsm_par_gen_tx
  import fsm_par_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter bit ODD_PAR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              par_bit
);

  logic [2:0] state_q, state_d;
  logic       acc_q, acc_d;
  logic       ser_q, ser_d;
  logic       rdy_q, rdy_d;
  logic       busy_q, busy_d;
  logic       par_q, par_d;
  logic       load, shift, last, bit_nxt;

  // Ready is only ever high in the states that may accept a word, so a handshake always loads.
  assign load  = in_valid && rdy_q;
  assign shift = (state_q == DATA) && !last;

  par_tx_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (load),
    .shift_i(shift),
    .din_i  (in_data),
    .bit_o  (bit_nxt),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      ser_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ser_q   <= ser_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (load) begin
`ifdef PAR_TX_FRAME_EN
        state_d = START;
`else
        state_d = DATA;
        acc_d   = in_data[0];
`endif
      end
`ifdef PAR_TX_FRAME_EN
      START: begin
        state_d = DATA;
        acc_d   = bit_nxt;
      end
`endif
      DATA: begin
        if (last) begin
          state_d = PARITY;
        end else begin
          acc_d = acc_q ^ bit_nxt;
        end
      end
`ifdef PAR_TX_FRAME_EN
      PARITY: state_d = STOP;
      STOP:   state_d = load ? START : IDLE;
`else
      PARITY: begin
        if (load) begin
          state_d = DATA;
          acc_d   = in_data[0];
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != IDLE);
    par_d  = (state_d == PARITY);
`ifdef PAR_TX_FRAME_EN
    rdy_d  = (state_d == IDLE) || (state_d == STOP);
`else
    rdy_d  = (state_d == IDLE) || (state_d == PARITY);
`endif
    case (state_d)
      DATA:    ser_d = load ? in_data[0] : bit_nxt;
      PARITY:  ser_d = acc_q ^ ODD_PAR;
`ifdef PAR_TX_FRAME_EN
      START:   ser_d = 1'b1;
`endif
      default: ser_d = 1'b0;
    endcase
  end

  assign in_ready = rdy_q;
  assign ser_out  = ser_q;
  assign busy     = busy_q;
  assign par_bit  = par_q;

endmodule

// File: tb/tb_fsm_par_gen_tx.sv
`timescale 1ns/1ps
// Bench for fsm_par_gen_tx: even- and odd-parity instances share stimulus; a per-cycle
// expected-line queue is filled at each handshake and drained on every falling edge.
module tb_fsm_par_gen_tx;
  import fsm_par_pkg::*;

`ifdef PAR_TX_FRAME_EN
  localparam int FR = 1;
`else
  localparam int FR = 0;
`endif

  typedef struct packed {
    logic ser;
    logic pc;
    logic rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ser_out, busy, par_bit;
  logic       rdy_o, ser_o, busy_o, par_o;

  exp_t exq[$];
  logic cur_rdy = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fsm_par_gen_tx #(.DATA_W(8), .ODD_PAR(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .busy(busy), .par_bit(par_bit)
  );

  fsm_par_gen_tx #(.DATA_W(8), .ODD_PAR(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_o), .ser_out(ser_o), .busy(busy_o), .par_bit(par_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic p, input logic r);
    exp_t e;
    e.ser = s;
    e.pc  = p;
    e.rdy = r;
    return e;
  endfunction

  task automatic push_frame(input logic [7:0] w);
`ifdef PAR_TX_FRAME_EN
    exq.push_back(mk(1'b1, 1'b0, 1'b0));
`endif
    for (int i = 0; i < 8; i++) exq.push_back(mk(w[i], 1'b0, 1'b0));
`ifdef PAR_TX_FRAME_EN
    exq.push_back(mk(par_of({24'h0, w}), 1'b1, 1'b0));
    exq.push_back(mk(1'b0, 1'b0, 1'b1));
`else
    exq.push_back(mk(par_of({24'h0, w}), 1'b1, 1'b1));
`endif
  endtask

  // Odd instance expects the parity bit inverted; an empty queue means idle line.
  always @(negedge clk) begin
    exp_t e;
    logic b;
    if (rst) begin
      b = (exq.size() != 0);
      if (b) e = exq.pop_front();
      else   e = mk(1'b0, 1'b0, 1'b1);
      check("cycle", {ser_out, ser_o, par_bit, par_o, in_ready, rdy_o, busy, busy_o},
                     {e.ser, e.ser ^ e.pc, e.pc, e.pc, e.rdy, e.rdy, b, b});
      cur_rdy = e.rdy;
    end
  end

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    exq.delete();
    cur_rdy = 1'b1;
    check("rst_async", {ser_out, busy, in_ready, par_bit, ser_o, busy_o, rdy_o, par_o},
                       8'b0010_0010);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Holds valid until the model says the word was taken; returns on the next falling edge.
  task automatic xfer(input logic [7:0] w);
    bit done = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk);
      if (cur_rdy) begin
        push_frame(w);
        done = 1'b1;
      end
    end
    check("xfer_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic poke(input logic [7:0] w);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk);
    if (cur_rdy) push_frame(w);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2;
    do_reset();
    idle(2);

    xfer(8'hA5); idle(14);
    xfer(8'h07); idle(14);

    xfer(8'hFF); xfer(8'h01); idle(14);

    xfer(8'hA5);
    repeat (3 + FR) @(negedge clk);
    #2;
    do_reset();
    idle(2);
    xfer(8'h3C); idle(14);

    xfer(8'h5A);
    repeat (2) @(negedge clk);
    poke(8'hC3);
    idle(14);

    for (int k = 0; k < 4; k++) xfer(8'($urandom));
    idle(14);

    check("drain", exq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fsm_par_gen_tx.md
Name: fsm_par_gen_tx

Overview:
Serial parity-generating transmitter, the send end of the serial parity link.
- Accepts a parallel word through a valid/ready handshake.
- Shifts the word out LSB-first on a single serial line, then appends one parity bit computed on the fly.
- Its output drives the serial input of the link's Mealy parity checker directly, sharing clk.

Parameters:
- DATA_W, 8: payload bits per frame; legal range 2..32.
- ODD_PAR, 0: 0 gives even parity (total ones incl. parity bit even); 1 gives odd parity.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserting low clears the block immediately; the block leaves reset on the first clk edge after rst goes high).
- in_data  in  DATA_W  parallel word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  serial line; idle level 0.
- busy  out  1  a frame is in progress.
- par_bit  out  1  high during the parity-bit cycle (frame-done marker).

Behaviour:
- Reset values: ser_out=0, in_ready=1, busy=0, par_bit=0, state=IDLE, shift register=0, bit counter=0, parity accumulator=0.
- States: IDLE, DATA, PARITY. All outputs are registered.
- Handshake:
  - A transfer occurs at a rising edge where in_valid && in_ready.
  - in_ready=1 in IDLE and in PARITY, 0 in DATA.
  - in_data is sampled only at the transfer edge; it may change freely otherwise.
- IDLE:
  - No transfer: stay in IDLE, ser_out=0.
  - Transfer: load the shift register, drive ser_out=in_data[0] from the next cycle, counter=0, acc=in_data[0], go to DATA.
- DATA:
  - One bit per cycle, LSB first; acc ^= each emitted bit.
  - After DATA_W bits have been on the line (counter==DATA_W-1), go to PARITY.
  - The next cycle carries ser_out = acc ^ ODD_PAR, with par_bit=1.
- PARITY lasts exactly one cycle. On exit:
  - Transfer on that edge: go straight to DATA with the new word's bit 0 (back-to-back frames, no gap).
  - Otherwise: return to IDLE, ser_out=0.
- Latency: transfer edge to first data bit on ser_out is 1 cycle. A frame occupies DATA_W+1 consecutive cycles.
- busy=1 in DATA and PARITY.
- in_valid held high continuously yields a gap-free stream of frames.
- Reset mid-frame: the frame is abandoned, outputs return to reset values at once, and no partial parity bit is emitted.
- Counter width is $clog2(DATA_W); it never wraps inside a frame and is cleared at each load.

Optional Feature:
- Macro PAR_TX_FRAME_EN.
- When defined:
  - Adds states START (before DATA) and STOP (after PARITY).
  - START drives ser_out=1 for one cycle; STOP drives ser_out=0 for one cycle.
  - A frame is DATA_W+3 cycles and first-bit latency becomes 2 cycles.
  - in_ready is asserted in IDLE and STOP instead of PARITY; back-to-back transfers go STOP -> START.
- When undefined: behaviour exactly as above, with no START/STOP logic.

Decomposition:
- Package fsm_par_pkg holds:
  - the state encoding localparams (IDLE, DATA, PARITY, START, STOP);
  - a function par_of(word) returning the XOR reduction, for the bench scoreboard.
- One natural sub-module, par_tx_shreg: DATA_W-bit load/shift register with bit counter and last-bit flag.
- The FSM and parity accumulator stay in the top.

Test Plan:
1. Reset then in_data=8'hA5, in_valid pulse, ODD_PAR=0 -> ser_out 1,0,1,0,0,1,0,1 then parity 0 with par_bit=1; in_ready back to 1 on the parity cycle.
2. in_data=8'h07, ODD_PAR=0 -> parity bit 1; same word with ODD_PAR=1 -> parity bit 0.
3. in_valid held high with words 8'hFF then 8'h01 -> 18 contiguous cycles:
   - 8 ones, parity 0;
   - then 1,0,0,0,0,0,0,0, parity 1;
   - busy never drops between frames.
4. rst driven low on the 4th data bit of 8'hA5 -> ser_out=0, busy=0 and in_ready=1 immediately (asynchronous); the next frame 8'h3C transmits correctly with parity 0.
5. in_valid pulsed during DATA -> ignored (in_ready=0); the current frame completes unchanged.
6. With PAR_TX_FRAME_EN, 8'hA5 -> ser_out 1 (start), 1,0,1,0,0,1,0,1, 0 (parity), 0 (stop); 11 cycles total.
